// File: rtl/jtmx5k_arb_pkg.sv
// Shared types and constants for the mx5k SDRAM read arbiter.
// rr_pick returns {found, slot} for the first pending slot after 'last'.
package jtmx5k_arb_pkg;

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    WAIT
  } state_t;

  localparam int N_SLOTS = 4;

  localparam logic [1:0] MAIN = 2'd0;
  localparam logic [1:0] GFX1 = 2'd1;
  localparam logic [1:0] PCM  = 2'd2;
  localparam logic [1:0] SND  = 2'd3;

  // Scanning from the farthest candidate down lets the closest one win.
  function automatic logic [2:0] rr_pick(input logic [3:0] pend, input logic [1:0] last);
    logic [2:0] r;
    logic [1:0] idx;
    r = 3'b000;
    for (int k = N_SLOTS; k >= 1; k--) begin
      idx = last + 2'(k);
      if (pend[idx]) r = {1'b1, idx};
    end
    return r;
  endfunction

endpackage

// File: rtl/jtmx5k_sdram_arb_if.sv
// ROM-slot and SDRAM read-port signals of the arbiter, bundled as one bus.
// The arbiter takes the slave view; the clients/controller side uses master.
interface jtmx5k_sdram_arb_if #(
  parameter int SLOT_AW  = 18,
  parameter int SDRAM_AW = 22
);
  logic [3:0]           slot_cs;
  logic [4*SLOT_AW-1:0] slot_addr;
  logic [3:0]           slot_ok;
  logic [63:0]          slot_dout;
  logic                 sdram_req;
  logic [SDRAM_AW-1:0]  sdram_addr;
  logic                 sdram_ack;
  logic                 data_rdy;
  logic [15:0]          data_read;
  logic                 busy;

  modport slave (
    input  slot_cs, slot_addr, sdram_ack, data_rdy, data_read,
    output slot_ok, slot_dout, sdram_req, sdram_addr, busy
  );

  modport master (
    output slot_cs, slot_addr, sdram_ack, data_rdy, data_read,
    input  slot_ok, slot_dout, sdram_req, sdram_addr, busy
  );
endinterface

// File: rtl/jtmx5k_arb_cache.sv
// One-word cache for a single ROM slot: word-address mapping, hit compare
// and byte lane selection for 8-bit slots.
module jtmx5k_arb_cache #(
  parameter int                  SLOT_AW  = 18,
  parameter int                  SDRAM_AW = 22,
  parameter logic [SDRAM_AW-1:0] OFFSET   = '0,
  parameter logic                IS8      = 1'b0
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                flush,
  input  logic                cs,
  input  logic [SLOT_AW-1:0]  addr,
  input  logic                fill,
  input  logic [SDRAM_AW-1:0] fill_addr,
  input  logic [15:0]         fill_data,
  output logic [SDRAM_AW-1:0] waddr,
  output logic                ok,
  output logic [15:0]         dout
);
  logic                valid_reg;
  logic [SDRAM_AW-1:0] tag_reg;
  logic [15:0]         data_reg;
  logic [SDRAM_AW-1:0] addr_ext;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_reg <= 1'b0;
      tag_reg   <= '0;
      data_reg  <= '0;
    end else if (flush) begin
      valid_reg <= 1'b0;
    end else if (fill) begin
      valid_reg <= 1'b1;
      tag_reg   <= fill_addr;
      data_reg  <= fill_data;
    end
  end

  // Address arithmetic wraps at the SDRAM width on purpose.
  assign addr_ext = SDRAM_AW'(addr);
  assign waddr    = OFFSET + (IS8 ? (addr_ext >> 1) : addr_ext);
  assign ok       = cs & valid_reg & (tag_reg == waddr);
  assign dout     = IS8 ? {8'h00, (addr[0] ? data_reg[15:8] : data_reg[7:0])} : data_reg;

endmodule

// File: rtl/jtmx5k_sdram_arb.sv
// Four-slot ROM read arbiter: per-slot one-word caches, round-robin miss
// service with a single SDRAM read in flight, flushed during ROM download.
module jtmx5k_sdram_arb
  import jtmx5k_arb_pkg::*;
#(
  parameter int                  SLOT_AW  = 18,
  parameter int                  SDRAM_AW = 22,
  parameter logic [3:0]          DW8      = 4'b1101,
  parameter logic [SDRAM_AW-1:0] OFFSET0  = '0,
  parameter logic [SDRAM_AW-1:0] OFFSET1  = '0,
  parameter logic [SDRAM_AW-1:0] OFFSET2  = '0,
  parameter logic [SDRAM_AW-1:0] OFFSET3  = '0
) (
  input logic               clk,
  input logic               rst,
  input logic               downloading,
  jtmx5k_sdram_arb_if.slave bus
);
  state_t              state_reg;
  logic [1:0]          gnt_slot_reg;
  logic [1:0]          last_grant_reg;
  logic [SDRAM_AW-1:0] gnt_addr_reg;
  logic                req_reg;

  logic [SDRAM_AW-1:0] waddr_w [N_SLOTS];
  logic [15:0]         dout_w  [N_SLOTS];
  logic                hit_w   [N_SLOTS];
  logic                fill_w  [N_SLOTS];

  logic [3:0]  hit;
  logic [3:0]  pend;
  logic [63:0] dout_all;
  logic [2:0]  pick;

  genvar gi;
  generate
    for (gi = 0; gi < N_SLOTS; gi++) begin : g_slot
      localparam logic [SDRAM_AW-1:0] OFF = (gi == 0) ? OFFSET0 :
                                            (gi == 1) ? OFFSET1 :
                                            (gi == 2) ? OFFSET2 : OFFSET3;

      assign fill_w[gi] = (state_reg == WAIT) && bus.data_rdy && (gnt_slot_reg == 2'(gi));

      jtmx5k_arb_cache #(
        .SLOT_AW (SLOT_AW),
        .SDRAM_AW(SDRAM_AW),
        .OFFSET  (OFF),
        .IS8     (DW8[gi])
      ) u_cache (
        .clk      (clk),
        .rst      (rst),
        .flush    (downloading),
        .cs       (bus.slot_cs[gi]),
        .addr     (bus.slot_addr[gi*SLOT_AW +: SLOT_AW]),
        .fill     (fill_w[gi]),
        .fill_addr(gnt_addr_reg),
        .fill_data(bus.data_read),
        .waddr    (waddr_w[gi]),
        .ok       (hit_w[gi]),
        .dout     (dout_w[gi])
      );
    end
  endgenerate

  always_comb begin
    hit      = '0;
    dout_all = '0;
    for (int k = 0; k < N_SLOTS; k++) begin
      hit[k]            = hit_w[k];
      dout_all[k*16 +: 16] = dout_w[k];
    end
    pend = bus.slot_cs & ~hit;
    pick = rr_pick(pend, last_grant_reg);
  end

  // Download wins over everything so a stale fill can never land in a cache.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg      <= IDLE;
      gnt_slot_reg   <= '0;
      last_grant_reg <= SND;
      gnt_addr_reg   <= '0;
      req_reg        <= 1'b0;
    end else if (downloading) begin
      state_reg <= IDLE;
      req_reg   <= 1'b0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (pick[2]) begin
            gnt_slot_reg <= pick[1:0];
            gnt_addr_reg <= waddr_w[pick[1:0]];
            req_reg      <= 1'b1;
            state_reg    <= REQ;
          end
        end
        REQ: begin
          if (bus.sdram_ack) begin
            req_reg   <= 1'b0;
            state_reg <= WAIT;
          end
        end
        WAIT: begin
          if (bus.data_rdy) begin
            last_grant_reg <= gnt_slot_reg;
            state_reg      <= IDLE;
          end
        end
        default: begin
          req_reg   <= 1'b0;
          state_reg <= IDLE;
        end
      endcase
    end
  end

  assign bus.slot_ok    = hit;
  assign bus.slot_dout  = dout_all;
  assign bus.sdram_req  = req_reg;
  assign bus.sdram_addr = gnt_addr_reg;
  assign bus.busy       = (state_reg != IDLE) | (|pend);

endmodule
